// File: rtl/alu_pkg.sv
// Shared opcode, function-code and state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [OP_W-1:0] ALU_OP_RTYPE = 2'b00;
  localparam logic [OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [OP_W-1:0] ALU_OP_RSVD  = 2'b10;
  localparam logic [OP_W-1:0] ALU_OP_ADD   = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV = 6'b011010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// MUL: {hi, lo} = a * b.  DIV: lo = a / b, hi = a % b (b == 0 gives lo = all ones, hi = a).
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;
  logic             mode;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] hi_d;

  // done flags the cycle whose edge computes the final bit
  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // One iteration step of either the multiplier or the divider
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - b_q;
    ge      = (shifted >= {1'b0, b_q});
    if (mode) begin
      hi_d = ge ? diff : shifted[WIDTH-1:0];
      lo_d = {lo[WIDTH-2:0], ge};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Load operands on start, then shift one bit per cycle until the counter empties
  always_ff @(posedge clock) begin
    if (reset) begin
      lo   <= '0;
      hi   <= '0;
      b_q  <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else if (start) begin
      lo   <= a;
      hi   <= '0;
      b_q  <= b;
      cnt  <= CNT_W'(WIDTH);
      mode <= is_div;
    end else if (busy) begin
      lo  <= lo_d;
      hi  <= hi_d;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes; MUL/DIV are iterative.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   read_data1,
  input  logic [WIDTH-1:0]   read_data2,
  input  logic [WIDTH-1:0]   sign_extend,
  input  logic               alu_src,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] alu_funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               div_by_zero,
  output logic               illegal
);

  alu_state_t state_q, state_d;

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] res_c;
  logic             iter_c;
  logic             div_c;
  logic             illegal_c;
  logic             accept_c;

  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             sel_iter_q;
  logic             divz_pend_q;

  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  assign b_sel    = alu_src ? sign_extend : read_data2;
  assign accept_c = in_valid && (state_q == S_IDLE) && !md_busy;

  // Decode the presented op and evaluate the single-cycle result
  always_comb begin
    res_c     = '0;
    iter_c    = 1'b0;
    div_c     = 1'b0;
    illegal_c = 1'b0;
    case (alu_op)
      ALU_OP_ADD: res_c = read_data1 + b_sel;
      ALU_OP_SUB: res_c = read_data1 - b_sel;
      ALU_OP_RTYPE: begin
        case (alu_funct)
          FUNCT_AND: res_c = read_data1 & b_sel;
          FUNCT_OR:  res_c = read_data1 | b_sel;
          FUNCT_ADD: res_c = read_data1 + b_sel;
          FUNCT_SUB: res_c = read_data1 - b_sel;
          FUNCT_MUL: iter_c = 1'b1;
          FUNCT_DIV: begin
            iter_c = 1'b1;
            div_c  = 1'b1;
          end
          default:   illegal_c = 1'b1;
        endcase
      end
      ALU_OP_RSVD: illegal_c = 1'b1;
      default:     illegal_c = 1'b1;
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (accept_c && iter_c),
    .is_div (div_c),
    .a      (read_data1),
    .b      (b_sel),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_c) state_d = iter_c ? S_ITER : S_DONE;
      S_ITER: if (md_done)  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and result registers; updated only on accept or completion
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
      sel_iter_q  <= 1'b0;
      divz_pend_q <= 1'b0;
    end else begin
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      if (accept_c) begin
        res_q       <= iter_c ? '0 : res_c;
        zero_q      <= !iter_c && (res_c == '0);
        illegal     <= illegal_c;
        div_by_zero <= 1'b0;
        sel_iter_q  <= 1'b0;
        divz_pend_q <= div_c && (b_sel == '0);
      end else if ((state_q == S_ITER) && md_done) begin
        sel_iter_q  <= 1'b1;
        div_by_zero <= divz_pend_q;
      end
    end
  end

  // Iterative results live in the mul/div registers, which hold once finished
  assign result    = sel_iter_q ? md_lo : res_q;
  assign result_hi = sel_iter_q ? md_hi : '0;
  assign zero      = sel_iter_q ? (md_lo == '0) : zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed table, multi-cycle corner sequences, random ops vs model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] read_data1 = '0;
  logic [W-1:0] read_data2 = '0;
  logic [W-1:0] sign_extend = '0;
  logic         alu_src = 1'b0;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   alu_funct = 6'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         div_by_zero;
  logic         illegal;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_multicycle #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .sign_extend (sign_extend),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .alu_funct   (alu_funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal     (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
    logic         ill;
    int           lat;
  } exp_t;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [5:0]   fn;
    logic         src;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] se;
    exp_t         e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the selected operands
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic src,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] se);
    exp_t         e;
    logic [W-1:0] bb;
    logic [63:0]  prod;
    bb    = src ? se : b;
    e.res = '0; e.hi = '0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
    if (op == 2'b11) e.res = a + bb;
    else if (op == 2'b01) e.res = a - bb;
    else if (op == 2'b10) e.ill = 1'b1;
    else if (fn == FUNCT_AND) e.res = a & bb;
    else if (fn == FUNCT_OR) e.res = a | bb;
    else if (fn == FUNCT_ADD) e.res = a + bb;
    else if (fn == FUNCT_SUB) e.res = a - bb;
    else if (fn == FUNCT_MUL) begin
      prod  = 64'(a) * 64'(bb);
      e.res = prod[W-1:0];
      e.hi  = prod[63:32];
      e.lat = W + 1;
    end else if (fn == FUNCT_DIV) begin
      e.lat = W + 1;
      if (bb == 0) begin
        e.res = '1; e.hi = a; e.dbz = 1'b1;
      end else begin
        e.res = a / bb; e.hi = a % bb;
      end
    end else e.ill = 1'b1;
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Present one op in IDLE, measure latency, check outputs, then drain it
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn, input logic src,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] se, input exp_t e);
    int lat;
    alu_op = op; alu_funct = fn; alu_src = src;
    read_data1 = a; read_data2 = b; sign_extend = se;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    read_data1 = $urandom; read_data2 = $urandom; sign_extend = $urandom;
    alu_op = 2'($urandom); alu_funct = 6'($urandom); alu_src = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock); @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_result"}, 64'(result), 64'(e.res));
    check({tag, "_result_hi"}, 64'(result_hi), 64'(e.hi));
    check({tag, "_zero"}, 64'(zero), 64'(e.zero));
    check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
    check({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_drain_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_drain_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h, input logic z,
                              input logic d, input logic il, input int l);
    exp_t e;
    e.res = r; e.hi = h; e.zero = z; e.dbz = d; e.ill = il; e.lat = l;
    return e;
  endfunction

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{"add25",   2'b00, FUNCT_ADD, 1'b0, 32'd25,       32'd25,    32'd0,  mk(32'd50, 0, 0, 0, 0, 1)};
    vecs[1]  = '{"beq_eq",  2'b01, 6'd0,      1'b0, 32'h1234,     32'h1234,  32'd0,  mk(32'd0, 0, 1, 0, 0, 1)};
    vecs[2]  = '{"beq_ne",  2'b01, 6'd0,      1'b0, 32'd5,        32'd7,     32'd0,  mk(32'hFFFF_FFFE, 0, 0, 0, 0, 1)};
    vecs[3]  = '{"mul_max", 2'b00, FUNCT_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2,    32'd0,  mk(32'hFFFF_FFFE, 32'd1, 0, 0, 0, 33)};
    vecs[4]  = '{"div100",  2'b00, FUNCT_DIV, 1'b0, 32'd100,      32'd7,     32'd0,  mk(32'd14, 32'd2, 0, 0, 0, 33)};
    vecs[5]  = '{"div0",    2'b00, FUNCT_DIV, 1'b0, 32'd9,        32'd0,     32'd0,  mk(32'hFFFF_FFFF, 32'd9, 0, 1, 0, 33)};
    vecs[6]  = '{"addi",    2'b11, 6'd0,      1'b1, 32'd1,        32'd1000,  32'd64, mk(32'd65, 0, 0, 0, 0, 1)};
    vecs[7]  = '{"and",     2'b00, FUNCT_AND, 1'b0, 32'hF0F0,     32'h0FF0,  32'd0,  mk(32'h00F0, 0, 0, 0, 0, 1)};
    vecs[8]  = '{"or",      2'b00, FUNCT_OR,  1'b0, 32'hF000,     32'h000F,  32'd0,  mk(32'hF00F, 0, 0, 0, 0, 1)};
    vecs[9]  = '{"sub_eq",  2'b00, FUNCT_SUB, 1'b0, 32'd3,        32'd3,     32'd0,  mk(32'd0, 0, 1, 0, 0, 1)};
    vecs[10] = '{"rsvd_op", 2'b10, FUNCT_ADD, 1'b0, 32'd4,        32'd5,     32'd0,  mk(32'd0, 0, 1, 0, 1, 1)};
    vecs[11] = '{"bad_fn",  2'b00, 6'b000000, 1'b0, 32'd4,        32'd5,     32'd0,  mk(32'd0, 0, 1, 0, 1, 1)};
    vecs[12] = '{"mul_0",   2'b00, FUNCT_MUL, 1'b0, 32'd0,        32'd5,     32'd0,  mk(32'd0, 32'd0, 1, 0, 0, 33)};
    vecs[13] = '{"div_lt",  2'b00, FUNCT_DIV, 1'b0, 32'd5,        32'd9,     32'd0,  mk(32'd0, 32'd5, 1, 0, 0, 33)};
    vecs[14] = '{"add_wrap",2'b00, FUNCT_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1,    32'd0,  mk(32'd0, 0, 1, 0, 0, 1)};

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_result_hi", 64'(result_hi), 64'(0));
    check("rst_flags", 64'({zero, div_by_zero, illegal}), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].se, vecs[i].e);

    // Backpressure after a MUL; an in_valid pulse in DONE must be ignored
    begin
      int lat;
      alu_op = 2'b00; alu_funct = FUNCT_MUL; alu_src = 1'b0;
      read_data1 = 32'd7; read_data2 = 32'd6; in_valid = 1'b1;
      @(posedge clock); @(negedge clock);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
        @(posedge clock); @(negedge clock);
        lat++;
      end
      check("bp_latency", 64'(lat), 64'(33));
      for (int c = 0; c < 10; c++) begin
        check("bp_result", 64'(result), 64'(42));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        if (c == 3) begin
          alu_op = 2'b11; read_data1 = 32'd1; read_data2 = 32'd1; in_valid = 1'b1;
        end
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      out_ready = 1'b0;
      check("bp_release_out_valid", 64'(out_valid), 64'(0));
      check("bp_release_in_ready", 64'(in_ready), 64'(1));
      @(posedge clock); @(negedge clock);
      check("bp_pulse_ignored", 64'(out_valid), 64'(0));
      check("bp_result_held", 64'(result), 64'(42));
    end

    // Reset in ITER cycle 10 of a DIV, then ADDI
    alu_op = 2'b00; alu_funct = FUNCT_DIV; alu_src = 1'b0;
    read_data1 = 32'd1000; read_data2 = 32'd3; in_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clock); @(negedge clock); end
    check("iter_no_valid", 64'(out_valid), 64'(0));
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_result_hi", 64'(result_hi), 64'(0));
    check("midrst_flags", 64'({zero, div_by_zero, illegal}), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    run_op("post_rst_addi", 2'b11, 6'd0, 1'b1, 32'd1, 32'd77, 32'd64, mk(32'd65, 0, 0, 0, 0, 1));

    // Random ops against the reference model
    begin
      logic [5:0] fns [6];
      fns = '{FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_DIV};
      for (int i = 0; i < 40; i++) begin
        int           k;
        logic [1:0]   op;
        logic [5:0]   fn;
        logic         src;
        logic [W-1:0] a, b, se;
        k   = int'($urandom_range(0, 8));
        src = 1'($urandom);
        a   = $urandom;
        b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        se  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        fn  = 6'($urandom);
        if (k == 0) op = 2'b11;
        else if (k == 1) op = 2'b01;
        else if (k == 8) op = 2'b10;
        else begin
          op = 2'b00;
          fn = fns[k - 2];
        end
        run_op("rand", op, fn, src, a, b, se, model(op, fn, src, a, b, se));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle execute-stage ALU. AND/OR/ADD/SUB and the address/branch modes complete in one cycle. MUL and DIV run on an iterative shift-add / restoring-divide datapath over WIDTH cycles. Operations are accepted and results returned through valid/ready handshakes, so the stage controller can stall on long operations instead of relying on a fixed stage count.

Parameters:
WIDTH, 32, operand and result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept; high only in IDLE
read_data1  input  WIDTH  operand A
read_data2  input  WIDTH  operand B when alu_src=0
sign_extend  input  WIDTH  operand B when alu_src=1
alu_src  input  1  B select
alu_op  input  2  00 R-type, 11 add (ADDI/LW/SW), 01 sub/compare (BEQ/BNE), 10 reserved
alu_funct  input  6  R-type function: 100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 011000 MUL, 011010 DIV
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  primary result (MUL low half, DIV quotient)
result_hi  output  WIDTH  MUL high half, DIV remainder, else 0
zero  output  1  result == 0
div_by_zero  output  1  DIV with B == 0
illegal  output  1  reserved alu_op or unknown funct

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- State machine: IDLE, ITER, DONE.
- Reset values: state=IDLE; in_ready=1; out_valid=0; result, result_hi, zero, div_by_zero and illegal all 0; counter=0.
- Reset mid-ITER or mid-DONE: operation is discarded. The next cycle shows reset values.
- Operand capture: on in_valid && in_ready, operands are registered with B = alu_src ? sign_extend : read_data2. Later input changes have no effect.
- IDLE, single-cycle op: result is computed and registered, state goes to DONE. Latency is 1 cycle from the accept edge to out_valid=1.
- IDLE, MUL or DIV: state goes to ITER and counter is loaded with WIDTH.
- ITER: one bit per cycle; counter decrements. When counter reaches 1, the final bit is computed and state goes to DONE. MUL/DIV latency is WIDTH+1 cycles from the accept edge to out_valid.
- DONE: out_valid=1. All outputs are held stable until out_ready=1. On out_valid && out_ready, state returns to IDLE; there is no back-to-back accept on the same edge.
- in_ready is 0 in ITER and DONE.
- Arithmetic: all unsigned. ADD/SUB wrap modulo 2^WIDTH. MUL gives the full 2*WIDTH-bit product as {result_hi, result}.
- DIV: result=quotient, result_hi=remainder.
- DIV with B=0: result is all ones, result_hi=A, div_by_zero=1. It still takes WIDTH+1 cycles.
- zero is evaluated on result for every op; alu_op=01 drives BEQ/BNE. zero is never left stale.
- illegal ops (alu_op=10, or alu_op=00 with an unknown funct): result=0, result_hi=0, zero=1, illegal=1, latency 1.
- Flags are cleared when the next operation is accepted.
- Output timing: outputs are registered and change only on accept or completion. No combinational path from in_* to out_*; in_ready depends only on state.

Decomposition:
- Shared package alu_pkg:
  - alu_op codes: ALU_OP_RTYPE, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_RSVD.
  - Function constants: FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_DIV.
  - State enum alu_state_t.
- Sub-module alu_iter_muldiv:
  - Holds the shift registers, counter and mode bit.
  - Ports: start, is_div, a, b, busy, done, lo, hi.
  - Top level keeps the FSM, the handshake and the single-cycle ops.

Test Plan:
1. Reset, then ADD with A=25, B=25, alu_op=00, funct=100000 -> out_valid 1 cycle after accept; result=50, zero=0; in_ready=0 until out_ready.
2. BEQ with alu_op=01, A=B=0x1234 -> result=0, zero=1. Then A=5, B=7 -> result=0xFFFFFFFE, zero=0.
3. MUL with A=0xFFFFFFFF, B=2 -> out_valid exactly 33 cycles after accept; result=0xFFFFFFFE, result_hi=1.
4. DIV with A=100, B=7 -> result=14, result_hi=2 after 33 cycles. DIV with A=9, B=0 -> result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
5. Backpressure: hold out_ready=0 for 10 cycles after a MUL completes -> outputs stable, in_ready=0; an in_valid pulse during DONE is ignored.
6. Assert reset in ITER cycle 10 of a DIV -> next cycle all outputs are 0, in_ready=1. A subsequent ADDI with alu_src=1, sign_extend=64, A=1 -> result=65.
